dac_spi_tx: RTL
===============

# dac_spi_tx

Serial-DAC transmitter for the filter output path: takes 12-bit filtered samples over a valid/ready handshake and shifts each one out as a 16-bit SPI write frame to an MCP4921-class DAC. After each frame it pulses LDAC to update the analog output. It is the output-side counterpart of the LTC2308 capture controller and runs on the same 40 MHz clock. A one-entry pending buffer lets the upstream filter hand over the next sample while the current frame is still in flight.

## Interface
- DATA_BITS, 12, sample width; frame is 4 config bits + DATA_BITS = 16
- SCK_HALF, 1, i_clk cycles per SCK half-period (1 → 20 MHz SCK)
- CS_SETUP, 1, cycles CS_N low before first SCK rise phase
- CS_HOLD, 1, cycles after last SCK high before CS_N rises
- LDAC_WIDTH, 2, cycles LDAC_N held low
- BUF_EN, 0, VREF buffer config bit
- GAIN_1X, 1, GA_N config bit (1 = 1x gain)
- i_clk  in  1  system clock, 40 MHz
- i_reset  in  1  asynchronous, active-low
- i_data  in  DATA_BITS  sample, unsigned straight binary
- i_channel  in  1  DAC select (0 = A, 1 = B), sampled with i_data
- i_valid  in  1  sample offered
- o_ready  out  1  can accept a sample this cycle
- o_busy  out  1  frame in progress (state ≠ IDLE)
- o_done  out  1  one-cycle pulse when a frame completes
- DAC_CS_N  out  1  chip select, active-low
- DAC_SCK  out  1  serial clock, idles low
- DAC_SDI  out  1  serial data, MSB first
- DAC_LDAC_N  out  1  latch strobe, active-low

## Operation
- Frame bits (MSB first): {i_channel, BUF_EN, GAIN_1X, 1'b1 (SHDN_N), i_data}.
- Accept: i_valid & o_ready at a rising edge.
  - If IDLE with no pending sample, the frame loads directly into the shift register.
  - Otherwise the sample goes to the pending register.
- o_ready = ~pending_valid. At most one frame in flight plus one pending.
- FSM states: IDLE → SETUP → SHIFT → HOLD → LDAC → IDLE.
  - IDLE: CS_N=1, SCK=0, LDAC_N=1. Move to SETUP on accept or when a pending sample exists; a pending sample loads the shift register and clears pending.
  - SETUP: CS_N=0, SDI=frame bit 15. Stays CS_SETUP cycles.
  - SHIFT: each bit lasts 2·SCK_HALF cycles, SCK low for the first half and high for the second. SDI changes only at bit start, i.e. with SCK falling; the DAC samples on SCK rise. There are 16 bits, counted by a 4-bit bit counter and a SCK_HALF phase counter.
  - HOLD: SCK=0, CS_N=0, for CS_HOLD cycles.
  - LDAC: CS_N=1, LDAC_N=0, for LDAC_WIDTH cycles. On the final cycle, o_done pulses and the FSM enters IDLE.
- The LDAC phase also provides the minimum CS_N-high time before the next frame.
- Simultaneous accept and o_done: the accepted sample goes to pending. It starts in the cycle after IDLE is entered.
- All DAC_* outputs come directly from registers, so there is no glitch on SCK.

## Timing
- Reset (async, any state) drives:
  - DAC_CS_N=1, DAC_SCK=0, DAC_SDI=0, DAC_LDAC_N=1
  - o_ready=1, o_busy=0, o_done=0
  - pending cleared, FSM to IDLE
  - The partial frame is abandoned and no LDAC is issued.
- Defaults, accept at edge E0:
  - E1: CS_N=0, SDI=bit15
  - E2: SHIFT, SCK low
  - E3: SCK high (bit15 sampled)
  - E33: bit0 SCK high
  - E34: HOLD
  - E35: CS_N=1, LDAC_N=0
  - E37: LDAC_N=1, o_done=1, IDLE
- Frame period with back-to-back samples: 38 cycles (≈1.05 MS/s). This exceeds the ADC sample rate, so o_ready never throttles steady-state streaming.
- General frame length: 1 + CS_SETUP + 32·SCK_HALF + CS_HOLD + LDAC_WIDTH cycles from accept to o_done.

## Structure
- Package dac_spi_pkg holds:
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, LDAC)
  - FRAME_BITS = 16, CFG_BITS = 4
  - Config-bit position constants
- Single module; no sub-module. The SCK phase counter stays inline.

## Test plan
- Reset values: hold i_reset low → all outputs at the reset values above. Release and idle 100 cycles → no CS_N activity.
- Single frame: i_data=12'hA5C, i_channel=0, one-cycle i_valid → SPI monitor decodes 16'h3A5C on SCK rising. CS_N is low E1–E34, LDAC_N is low E35–E36, and o_done pulses at E37.
- Back-to-back: samples 12'h000, 12'hFFF, 12'h800 with i_valid held high → o_ready drops after the second accept and returns when the second frame loads. Frames decode 3000, 3FFF, 3800, spaced 38 cycles.
- Accept coinciding with o_done, channel B, i_data=12'h123 → frame B123 starts the cycle after IDLE. No sample is lost or duplicated.
- Reset mid-SHIFT (bit 7): assert i_reset → CS_N=1 and SCK=0 immediately, no LDAC pulse. A subsequent 12'h456 frame decodes correctly.
- Parameter sweep SCK_HALF=2, CS_HOLD=3 → SCK is 10 MHz with 50% duty, and accept-to-o_done is 1+1+64+3+2 = 71 cycles.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// Shared constants and FSM encoding for the MCP4921-class serial-DAC transmitter.
package dac_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CFG_BITS   = 4;

    // Config-bit positions inside the 16-bit write frame (MSB first on the wire).
    localparam int CH_POS   = 15;
    localparam int BUF_POS  = 14;
    localparam int GA_POS   = 13;
    localparam int SHDN_POS = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LDAC
    } state_t;

endpackage

// File: rtl/dac_spi_tx.sv
// Serial-DAC transmitter: accepts samples over valid/ready, shifts 16-bit SPI write
// frames out MSB first, then strobes LDAC. One pending slot lets upstream run ahead.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int   DATA_BITS  = 12,
    parameter int   SCK_HALF   = 1,
    parameter int   CS_SETUP   = 1,
    parameter int   CS_HOLD    = 1,
    parameter int   LDAC_WIDTH = 2,
    parameter logic BUF_EN     = 1'b0,
    parameter logic GAIN_1X    = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_channel,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 DAC_CS_N,
    output logic                 DAC_SCK,
    output logic                 DAC_SDI,
    output logic                 DAC_LDAC_N
);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    half_q, half_d;
    logic [3:0]              bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]   pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [FRAME_BITS-1:0]   frame_in;

    logic cs_n_q, sck_q, sdi_q, ldac_n_q, done_q;

    logic accept;
    logic out_idle;

    assign accept   = i_valid && !pend_valid_q;
    // The previous LDAC strobe must have left the pins before a new frame may start,
    // which also guarantees the minimum CS_N-high time between frames.
    assign out_idle = ldac_n_q;

    always_comb begin
        frame_in                   = '0;
        frame_in[CH_POS]           = i_channel;
        frame_in[BUF_POS]          = BUF_EN;
        frame_in[GA_POS]           = GAIN_1X;
        frame_in[SHDN_POS]         = 1'b1;
        frame_in[DATA_BITS-1:0]    = i_data;
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (state_q == IDLE) begin
            if (pend_valid_q && out_idle) begin
                shreg_d      = pend_q;
                pend_valid_d = 1'b0;
                state_d      = SETUP;
                cnt_d        = '0;
            end else if (accept && out_idle) begin
                shreg_d = frame_in;
                state_d = SETUP;
                cnt_d   = '0;
            end else if (accept) begin
                pend_d       = frame_in;
                pend_valid_d = 1'b1;
            end
        end else if (accept) begin
            pend_d       = frame_in;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            SETUP: begin
                if (cnt_q == 8'(CS_SETUP - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == 8'(SCK_HALF - 1)) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        // End of the high half: next bit starts together with SCK falling.
                        half_d  = 1'b0;
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'(FRAME_BITS - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'(CS_HOLD - 1)) begin
                    state_d = LDAC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LDAC: begin
                if (cnt_q == 8'(LDAC_WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            half_q       <= 1'b0;
            bit_q        <= '0;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Pin registers follow the FSM by one cycle, so SCK and friends never glitch.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            ldac_n_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            cs_n_q   <= !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
            sck_q    <= (state_q == SHIFT) && half_q;
            ldac_n_q <= (state_q != LDAC);
            done_q   <= (state_q == IDLE) && !ldac_n_q;
            if (state_q == SETUP || state_q == SHIFT) begin
                sdi_q <= shreg_q[FRAME_BITS-1];
            end else if (state_q != HOLD) begin
                sdi_q <= 1'b0;
            end
        end
    end

    assign o_ready    = ~pend_valid_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;
    assign DAC_CS_N   = cs_n_q;
    assign DAC_SCK    = sck_q;
    assign DAC_SDI    = sdi_q;
    assign DAC_LDAC_N = ldac_n_q;

endmodule
